silence_detector: RTL and testbench
===================================

// Module: silence_detector
// PURPOSE
// Downstream monitor for the stereo audio path: the counterpart of the mute stage, it detects silence instead of producing it.
// Watches the L/R sample stream and flags when both channels stay within +/-thresh for SILENCE_SAMPLES consecutive samples.
// Uses hysteresis so isolated samples do not toggle the flag. Drives LEDs/auto-standby and confirms that mute works on hardware.
// PARAMETERS
// DATA_W           32    sample width, signed two's complement
// SILENCE_SAMPLES  4800  consecutive quiet samples to enter SILENT (100 ms @ 48 kHz); must be >= 1
// RESUME_SAMPLES   4     consecutive loud samples to leave SILENT; must be >= 1
// CNT_W            $clog2(SILENCE_SAMPLES+1)  run counter width; derived, do not override
// PORTS
// clk            in   1          system clock
// reset          in   1          asynchronous, active-high
// enable         in   1          detector on; low = bypass/idle
// sample_valid   in   1          one-cycle strobe per stereo sample frame
// in_L, in_R     in   DATA_W     signed samples, valid with sample_valid
// thresh         in   DATA_W-1   unsigned magnitude threshold, inclusive
// silent         out  1          level: stream is currently silent
// silence_start  out  1          one-cycle pulse on the transition into SILENT
// silence_end    out  1          one-cycle pulse on the transition out of SILENT
// run_len        out  CNT_W      current quiet-run length, saturating
// BEHAVIOUR
// - Reset: state=ACTIVE, silent=0, both pulses=0, run_len=0, stage-1 regs=0. All flops use async reset.
// - Stage 1: on sample_valid, register quiet = (satabs(in_L)<=thresh) && (satabs(in_R)<=thresh), and register v1=1.
//   satabs(-2^(DATA_W-1)) = 2^(DATA_W-1)-1. No other arithmetic widening.
// - Stage 2: the FSM advances only when v1=1 and holds otherwise. Outputs change at the edge after stage 1: 2-cycle latency from sample_valid.
// - States: ACTIVE, QUALIFY, SILENT, RESUME (enum).
//   ACTIVE : quiet -> QUALIFY, cnt=1 (-> SILENT directly if SILENCE_SAMPLES==1); loud -> stay, cnt=0.
//   QUALIFY: quiet -> cnt++; cnt+1==SILENCE_SAMPLES -> SILENT. Loud -> ACTIVE, cnt=0.
//   SILENT : loud -> RESUME, lcnt=1 (-> ACTIVE directly if RESUME_SAMPLES==1). Quiet -> stay.
//   RESUME : loud -> lcnt++; lcnt+1==RESUME_SAMPLES -> ACTIVE, cnt=0. Quiet -> SILENT, lcnt=0.
// - silent=1 in SILENT and RESUME. silence_start pulses exactly on entry to SILENT from QUALIFY/ACTIVE only, never on RESUME->SILENT.
//   silence_end pulses only on the exit to ACTIVE.
// - run_len = cnt. It saturates at SILENCE_SAMPLES, holds that value in SILENT/RESUME, and clears on exit to ACTIVE. It never wraps.
// - enable low: synchronously clears to the reset state on the next edge (no pulses) and ignores samples; resumes from ACTIVE when raised.
// - thresh changes apply to the next registered sample. Counters are not reset on a thresh change.
// - sample_valid on consecutive cycles is legal: full throughput, one sample per clock.
// - reset asserted mid-run: immediate return to the reset state; no pulse is emitted on release.
// STRUCTURE
// - audio_pkg: typedef logic signed [31:0] sample_t; typedef enum {ACTIVE,QUALIFY,SILENT,RESUME} silence_state_e.
// - Sub-module sat_abs (combinational saturating magnitude, DATA_W param), instantiated once per channel.
// - Top level: stage-1 regs plus FSM with counters cnt and lcnt in a single always_ff, and next-state logic in always_comb.
// TESTING (bench: SILENCE_SAMPLES=8, RESUME_SAMPLES=2, thresh=100, enable=1)
// - Reset mid-QUALIFY (after 5 quiet samples): outputs 0 immediately; 8 quiet samples after release -> silence_start once.
// - 8 samples of L=R=0 -> silence_start one pulse 2 clk after the 8th strobe; silent=1; run_len=8 held.
// - 7 quiet, 1 loud (L=101), 8 quiet -> no pulse until the 16th sample; run_len goes 7,0,1..8.
// - In SILENT: 1 loud, then quiet -> silent stays 1, no pulses. Then 2 loud (R=-200) -> silence_end pulse, silent=0, run_len=0.
// - Boundaries: L=100/-100 counts as quiet, L=101 as loud. L=-2^31 is treated as loud (saturates, no overflow to quiet).
// - enable dropped while SILENT -> silent=0 next edge with no silence_end; samples during enable=0 are ignored.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types for the stereo audio monitoring path.
package audio_pkg;

  localparam int SAMPLE_W = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    QUALIFY = 2'd1,
    SILENT  = 2'd2,
    RESUME  = 2'd3
  } silence_state_e;

  // RESUME still reports silence: the stream has not yet proven it is loud.
  function automatic logic is_silent_state(input silence_state_e s);
    return (s == SILENT) || (s == RESUME);
  endfunction

endpackage

// File: rtl/sat_abs.sv
// Combinational saturating magnitude of a signed sample; the most negative
// code maps to the largest positive magnitude instead of wrapping to zero.
module sat_abs #(
  parameter int DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] val_i,
  output logic        [DATA_W-2:0] mag_o
);

  always_comb begin
    if (!val_i[DATA_W-1]) begin
      mag_o = val_i[DATA_W-2:0];
    end else if (val_i[DATA_W-2:0] == '0) begin
      mag_o = '1;
    end else begin
      mag_o = ~val_i[DATA_W-2:0] + (DATA_W-1)'(1);
    end
  end

endmodule

// File: rtl/silence_detector.sv
// Stereo silence detector: one register stage computes per-frame quietness,
// a hysteresis FSM turns runs of quiet/loud frames into a silent flag and pulses.
module silence_detector
  import audio_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int SILENCE_SAMPLES = 4800,
  parameter int RESUME_SAMPLES  = 4,
  parameter int CNT_W           = $clog2(SILENCE_SAMPLES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] in_L,
  input  logic signed [DATA_W-1:0] in_R,
  input  logic        [DATA_W-2:0] thresh,
  output logic                     silent,
  output logic                     silence_start,
  output logic                     silence_end,
  output logic        [CNT_W-1:0]  run_len
);

  localparam int LCNT_W = $clog2(RESUME_SAMPLES + 1);
  localparam logic [CNT_W-1:0]  SIL_LAST = CNT_W'(SILENCE_SAMPLES);
  localparam logic [LCNT_W-1:0] RES_LAST = LCNT_W'(RESUME_SAMPLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [LCNT_W-1:0] LCNT_ONE = LCNT_W'(1);

  logic [DATA_W-2:0] mag_l_s;
  logic [DATA_W-2:0] mag_r_s;
  logic              quiet_s;

  logic              v1_q;
  logic              quiet_q;

  silence_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              silent_q;
  logic              start_q, start_d;
  logic              end_q, end_d;

  sat_abs #(.DATA_W(DATA_W)) u_abs_l (.val_i(in_L), .mag_o(mag_l_s));
  sat_abs #(.DATA_W(DATA_W)) u_abs_r (.val_i(in_R), .mag_o(mag_r_s));

  assign quiet_s = (mag_l_s <= thresh) && (mag_r_s <= thresh);

  // Next-state logic; the FSM only moves when a registered frame is present.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcnt_d  = lcnt_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    if (v1_q) begin
      case (state_q)
        ACTIVE: begin
          if (quiet_q) begin
            cnt_d = CNT_ONE;
            if (SIL_LAST == CNT_ONE) begin
              state_d = SILENT;
              start_d = 1'b1;
            end else begin
              state_d = QUALIFY;
            end
          end else begin
            cnt_d = '0;
          end
        end
        QUALIFY: begin
          if (quiet_q) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q + CNT_ONE == SIL_LAST) begin
              state_d = SILENT;
              start_d = 1'b1;
            end else begin
              state_d = QUALIFY;
            end
          end else begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end
        end
        SILENT: begin
          if (!quiet_q) begin
            if (RES_LAST == LCNT_ONE) begin
              state_d = ACTIVE;
              cnt_d   = '0;
              lcnt_d  = '0;
              end_d   = 1'b1;
            end else begin
              state_d = RESUME;
              lcnt_d  = LCNT_ONE;
            end
          end else begin
            state_d = SILENT;
          end
        end
        RESUME: begin
          if (!quiet_q) begin
            if (lcnt_q + LCNT_ONE == RES_LAST) begin
              state_d = ACTIVE;
              cnt_d   = '0;
              lcnt_d  = '0;
              end_d   = 1'b1;
            end else begin
              lcnt_d  = lcnt_q + LCNT_ONE;
            end
          end else begin
            state_d = SILENT;
            lcnt_d  = '0;
          end
        end
        default: begin
          state_d = ACTIVE;
          cnt_d   = '0;
          lcnt_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Stage-1 capture plus FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q     <= 1'b0;
      quiet_q  <= 1'b0;
      state_q  <= ACTIVE;
      cnt_q    <= '0;
      lcnt_q   <= '0;
      silent_q <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
    end else if (!enable) begin
      v1_q     <= 1'b0;
      quiet_q  <= 1'b0;
      state_q  <= ACTIVE;
      cnt_q    <= '0;
      lcnt_q   <= '0;
      silent_q <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      v1_q <= sample_valid;
      if (sample_valid) begin
        quiet_q <= quiet_s;
      end
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lcnt_q   <= lcnt_d;
      silent_q <= is_silent_state(state_d);
      start_q  <= start_d;
      end_q    <= end_d;
    end
  end

  assign silent        = silent_q;
  assign silence_start = start_q;
  assign silence_end   = end_q;
  assign run_len       = cnt_q;

endmodule

// File: tb/tb_silence_detector.sv
// Scoreboard bench for silence_detector (SILENCE_SAMPLES=8, RESUME_SAMPLES=2, thresh=100).
module tb_silence_detector;
  import audio_pkg::*;

  localparam int SS = 8;
  localparam int RS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_valid;
  sample_t     in_L;
  sample_t     in_R;
  logic [30:0] thresh;
  logic        silent;
  logic        silence_start;
  logic        silence_end;
  logic [3:0]  run_len;

  silence_detector #(
    .DATA_W(32),
    .SILENCE_SAMPLES(SS),
    .RESUME_SAMPLES(RS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sample_valid(sample_valid),
    .in_L(in_L),
    .in_R(in_R),
    .thresh(thresh),
    .silent(silent),
    .silence_start(silence_start),
    .silence_end(silence_end),
    .run_len(run_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sil;
    logic       st;
    logic       en;
    logic [3:0] rl;
  } obs_t;

  typedef struct {
    int   due;
    obs_t o;
  } sb_t;

  sb_t  sb[$];
  obs_t hold;
  int   edge_n;
  int   checks;
  int   errors;
  bit   mon_en;
  int   starts_seen;
  int   ends_seen;
  int   last_start_edge;
  int   last_end_edge;
  int   rl_seen[$];

  int   m_state;
  int   m_cnt;
  int   m_lcnt;

  function automatic void model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_lcnt  = 0;
  endfunction

  function automatic longint mag(input sample_t x);
    longint v;
    v = longint'(x);
    if (v == -64'sd2147483648) return 64'sd2147483647;
    if (v < 0) return -v;
    return v;
  endfunction

  function automatic bit quiet_m(input sample_t l, input sample_t r);
    return (mag(l) <= longint'(thresh)) && (mag(r) <= longint'(thresh));
  endfunction

  // Reference behaviour: state 0=ACTIVE 1=QUALIFY 2=SILENT 3=RESUME.
  function automatic obs_t model_step(input bit q);
    obs_t o;
    o = '0;
    case (m_state)
      0: if (q) begin
           m_cnt = 1;
           if (SS == 1) begin m_state = 2; o.st = 1'b1; end
           else m_state = 1;
         end else m_cnt = 0;
      1: if (q) begin
           m_cnt = m_cnt + 1;
           if (m_cnt == SS) begin m_state = 2; o.st = 1'b1; end
         end else begin m_state = 0; m_cnt = 0; end
      2: if (!q) begin
           if (RS == 1) begin m_state = 0; m_cnt = 0; m_lcnt = 0; o.en = 1'b1; end
           else begin m_state = 3; m_lcnt = 1; end
         end
      default: if (!q) begin
           m_lcnt = m_lcnt + 1;
           if (m_lcnt == RS) begin m_state = 0; m_cnt = 0; m_lcnt = 0; o.en = 1'b1; end
         end else begin m_state = 2; m_lcnt = 0; end
    endcase
    o.sil = (m_state == 2) || (m_state == 3);
    o.rl  = 4'(m_cnt);
    return o;
  endfunction

  // Output monitor: pops the scoreboard when a frame's result is due,
  // otherwise expects held levels with no pulses.
  always @(negedge clk) begin
    obs_t obs;
    obs_t exp;
    if (mon_en) begin
      obs = {silent, silence_start, silence_end, run_len};
      exp = hold;
      if (sb.size() > 0 && sb[0].due == edge_n) begin
        exp = sb[0].o;
        void'(sb.pop_front());
        hold    = exp;
        hold.st = 1'b0;
        hold.en = 1'b0;
        rl_seen.push_back(int'(run_len));
      end
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL scoreboard edge %0d: got sil=%b start=%b end=%b run=%0d, want sil=%b start=%b end=%b run=%0d",
                 edge_n, obs.sil, obs.st, obs.en, obs.rl, exp.sil, exp.st, exp.en, exp.rl);
      end
      if (silence_start === 1'b1) begin starts_seen++; last_start_edge = edge_n; end
      if (silence_end === 1'b1) begin ends_seen++; last_end_edge = edge_n; end
    end
  end

  task automatic tick(input bit v, input sample_t l, input sample_t r);
    obs_t o;
    sample_valid = v;
    in_L = l;
    in_R = r;
    @(posedge clk);
    edge_n++;
    if (reset || !enable) begin
      sb.delete();
      model_reset();
      hold = '0;
    end else if (v) begin
      o = model_step(quiet_m(l, r));
      sb.push_back('{edge_n + 1, o});
    end
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'sd0, 32'sd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    model_reset();
    hold = '0;
    idle(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({silent, silence_start, silence_end, run_len} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: got %b want 0000000", {silent, silence_start, silence_end, run_len});
    end
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_reset_mid_qualify();
    int s0;
    for (int i = 0; i < 5; i++) tick(1'b1, 32'sd0, 32'sd0);
    idle(2);
    checks++;
    if (run_len !== 4'd5) begin errors++; $display("FAIL midq_run5: got %0d want 5", run_len); end
    #2;
    reset = 1'b1;
    sb.delete();
    model_reset();
    hold = '0;
    #1;
    checks++;
    if ({silent, silence_start, silence_end, run_len} !== 7'd0) begin
      errors++;
      $display("FAIL midq_reset_now: got %b want 0000000", {silent, silence_start, silence_end, run_len});
    end
    tick(1'b0, 32'sd0, 32'sd0);
    reset = 1'b0;
    s0 = starts_seen;
    for (int i = 0; i < 8; i++) tick(1'b1, 32'sd0, 32'sd0);
    idle(3);
    checks++;
    if (starts_seen - s0 !== 1) begin errors++; $display("FAIL midq_starts: got %0d want 1", starts_seen - s0); end
  endtask

  task automatic test_basic_silence();
    int s0, n0, e8;
    do_reset();
    s0 = starts_seen;
    n0 = ends_seen;
    for (int i = 0; i < 8; i++) tick(1'b1, 32'sd0, 32'sd0);
    e8 = edge_n;
    idle(6);
    checks++;
    if (starts_seen - s0 !== 1) begin errors++; $display("FAIL basic_starts: got %0d want 1", starts_seen - s0); end
    checks++;
    if (last_start_edge !== e8 + 1) begin errors++; $display("FAIL basic_start_edge: got %0d want %0d", last_start_edge, e8 + 1); end
    checks++;
    if (silent !== 1'b1 || run_len !== 4'd8) begin
      errors++; $display("FAIL basic_held: got silent=%b run=%0d want silent=1 run=8", silent, run_len);
    end
    checks++;
    if (ends_seen !== n0) begin errors++; $display("FAIL basic_no_end: got %0d want %0d", ends_seen, n0); end
  endtask

  task automatic test_broken_run();
    int s0, e16;
    int exp_rl[16] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7, 8};
    do_reset();
    rl_seen.delete();
    s0 = starts_seen;
    for (int i = 0; i < 7; i++) tick(1'b1, 32'sd0, 32'sd0);
    tick(1'b1, 32'sd101, 32'sd0);
    for (int i = 0; i < 8; i++) tick(1'b1, 32'sd0, 32'sd0);
    e16 = edge_n;
    idle(2);
    checks++;
    if (rl_seen.size() !== 16) begin
      errors++; $display("FAIL break_rl_len: got %0d want 16", rl_seen.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (rl_seen[i] !== exp_rl[i]) begin
          errors++; $display("FAIL break_rl[%0d]: got %0d want %0d", i, rl_seen[i], exp_rl[i]);
        end
      end
    end
    checks++;
    if (starts_seen - s0 !== 1 || last_start_edge !== e16 + 1) begin
      errors++; $display("FAIL break_start: got count=%0d edge=%0d want count=1 edge=%0d",
                         starts_seen - s0, last_start_edge, e16 + 1);
    end
  endtask

  task automatic test_resume();
    int s0, n0, e2;
    s0 = starts_seen;
    n0 = ends_seen;
    tick(1'b1, 32'sd101, 32'sd0);
    for (int i = 0; i < 3; i++) tick(1'b1, 32'sd0, 32'sd0);
    idle(2);
    checks++;
    if (silent !== 1'b1 || starts_seen !== s0 || ends_seen !== n0) begin
      errors++; $display("FAIL resume_glitch: got silent=%b starts+%0d ends+%0d want silent=1 +0 +0",
                         silent, starts_seen - s0, ends_seen - n0);
    end
    tick(1'b1, 32'sd0, -32'sd200);
    tick(1'b1, 32'sd0, -32'sd200);
    e2 = edge_n;
    idle(2);
    checks++;
    if (ends_seen - n0 !== 1 || last_end_edge !== e2 + 1) begin
      errors++; $display("FAIL resume_end: got count=%0d edge=%0d want count=1 edge=%0d",
                         ends_seen - n0, last_end_edge, e2 + 1);
    end
    checks++;
    if (silent !== 1'b0 || run_len !== 4'd0) begin
      errors++; $display("FAIL resume_levels: got silent=%b run=%0d want 0 0", silent, run_len);
    end
  endtask

  task automatic test_boundaries();
    int s0;
    sample_t most_neg;
    most_neg = 32'sh8000_0000;
    do_reset();
    s0 = starts_seen;
    for (int i = 0; i < 8; i++) tick(1'b1, (i % 2 == 0) ? 32'sd100 : -32'sd100, -32'sd100);
    idle(2);
    checks++;
    if (starts_seen - s0 !== 1 || silent !== 1'b1) begin
      errors++; $display("FAIL bound_100_quiet: got starts=%0d silent=%b want 1 1", starts_seen - s0, silent);
    end
    do_reset();
    for (int i = 0; i < 7; i++) tick(1'b1, 32'sd0, 32'sd0);
    tick(1'b1, most_neg, 32'sd0);
    idle(2);
    checks++;
    if (run_len !== 4'd0 || silent !== 1'b0) begin
      errors++; $display("FAIL bound_most_neg: got run=%0d silent=%b want 0 0", run_len, silent);
    end
    tick(1'b1, 32'sd0, most_neg);
    idle(2);
    checks++;
    if (run_len !== 4'd0) begin errors++; $display("FAIL bound_most_neg_r: got %0d want 0", run_len); end
  endtask

  task automatic test_enable();
    int n0;
    do_reset();
    for (int i = 0; i < 8; i++) tick(1'b1, 32'sd0, 32'sd0);
    idle(2);
    checks++;
    if (silent !== 1'b1) begin errors++; $display("FAIL en_pre_silent: got %b want 1", silent); end
    n0 = ends_seen;
    enable = 1'b0;
    tick(1'b0, 32'sd0, 32'sd0);
    checks++;
    if (silent !== 1'b0 || run_len !== 4'd0) begin
      errors++; $display("FAIL en_clear: got silent=%b run=%0d want 0 0", silent, run_len);
    end
    for (int i = 0; i < 8; i++) tick(1'b1, 32'sd0, 32'sd0);
    idle(1);
    checks++;
    if (ends_seen !== n0 || silent !== 1'b0 || run_len !== 4'd0) begin
      errors++; $display("FAIL en_ignored: got ends+%0d silent=%b run=%0d want +0 0 0", ends_seen - n0, silent, run_len);
    end
    enable = 1'b1;
    tick(1'b1, 32'sd0, 32'sd0);
    idle(2);
    checks++;
    if (run_len !== 4'd1 || silent !== 1'b0) begin
      errors++; $display("FAIL en_resume: got run=%0d silent=%b want 1 0", run_len, silent);
    end
  endtask

  task automatic test_back_to_back_thresh();
    int n0;
    do_reset();
    thresh = 31'd300;
    for (int i = 0; i < 4; i++) tick(1'b1, 32'sd50, -32'sd200);
    thresh = 31'd250;
    for (int i = 0; i < 4; i++) tick(1'b1, -32'sd250, 32'sd200);
    idle(2);
    checks++;
    if (silent !== 1'b1 || run_len !== 4'd8) begin
      errors++; $display("FAIL thresh_silent: got silent=%b run=%0d want 1 8", silent, run_len);
    end
    thresh = 31'd100;
    n0 = ends_seen;
    tick(1'b1, 32'sd0, -32'sd200);
    tick(1'b1, 32'sd0, -32'sd200);
    idle(2);
    checks++;
    if (ends_seen - n0 !== 1 || silent !== 1'b0) begin
      errors++; $display("FAIL thresh_exit: got ends=%0d silent=%b want 1 0", ends_seen - n0, silent);
    end
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    sample_valid = 1'b0;
    in_L         = 32'sd0;
    in_R         = 32'sd0;
    thresh       = 31'd100;
    edge_n       = 0;
    checks       = 0;
    errors       = 0;
    starts_seen  = 0;
    ends_seen    = 0;
    last_start_edge = -1;
    last_end_edge   = -1;
    hold         = '0;
    model_reset();
    mon_en       = 1'b1;

    test_reset();
    test_reset_mid_qualify();
    test_basic_silence();
    test_broken_run();
    test_resume();
    test_boundaries();
    test_enable();
    test_back_to_back_thresh();
    idle(3);

    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
